// File: rtl/spi_burst_controller.sv
// spi_burst_controller: runs command/address/data byte bursts through an SPI byte engine, on request or poll tick
//   clk, rst_n           : clock, async active-low reset
//   poll_en, req         : periodic poll enable, one-shot transaction request
//   mode_write, cfg_addr, cfg_len : transaction setup, latched at start
//   wr_data / wr_pop     : write byte source and its consume strobe
//   rd_data / rd_valid / rd_index : received data bytes
//   busy, done, err, missed_tick  : status pulses and activity flag
//   tx_byte, start, spi_active, rx_data : byte engine handshake
//   ncs_o, clk_enable    : chip select (active low), SPI clock enable
module spi_burst_controller #(
  parameter int POLL_PERIOD = 10000,
  parameter int MAX_LEN     = 8,
  parameter int LEN_W       = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int CS_GAP      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             poll_en,
  input  logic             req,
  input  logic             mode_write,
  input  logic [7:0]       cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [7:0]       wr_data,
  output logic             wr_pop,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [LEN_W-1:0] rd_index,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             missed_tick,
  output logic [7:0]       tx_byte,
  output logic             start,
  input  logic             spi_active,
  input  logic [7:0]       rx_data,
  output logic             ncs_o,
  output logic             clk_enable
);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int IW = LEN_W + 1;
  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT_ACK, WAIT_DONE, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d, rd_index_q, rd_index_d;
  logic [7:0] addr_q, addr_d, rd_data_q, rd_data_d, tx_byte_q, tx_byte_d;
  logic pend_q, pend_d, mode_q, mode_d, tick;
  logic wr_pop_q, wr_pop_d, rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;
  logic err_q, err_d, missed_q, missed_d, start_q, start_d, ncs_q, ncs_d, clk_en_q, clk_en_d;
  always_comb begin
    tick = poll_en && (poll_q == PW'(POLL_PERIOD - 1));
    poll_d = (!poll_en || tick) ? '0 : poll_q + PW'(1);
    state_d = state_q;
    pend_d = pend_q | req;
    mode_d = mode_q;
    addr_d = addr_q;
    len_d = len_q;
    idx_d = idx_q;
    tmr_d = (state_q == WAIT_ACK) ? tmr_q + TW'(1) : TW'(1);
    gap_d = gap_q + GW'(1);
    rd_data_d = rd_data_q;
    rd_index_d = rd_index_q;
    rd_valid_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    missed_d = tick && (state_q != IDLE);
    case (state_q)
      IDLE: if (req || tick || pend_q) begin
        state_d = SETUP;
        pend_d = 1'b0;
        mode_d = mode_write;
        addr_d = cfg_addr;
        len_d = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      end
      SETUP: begin
        state_d = SEND;
        idx_d = '0;
      end
      SEND: state_d = WAIT_ACK;
      // tmr counts cycles since the start strobe, so the abort lands ACK_TIMEOUT cycles after it
      WAIT_ACK: if (spi_active) state_d = WAIT_DONE;
        else if (tmr_q >= TW'(ACK_TIMEOUT - 1)) begin
          state_d = GAP;
          err_d = 1'b1;
          gap_d = '0;
        end
      WAIT_DONE: if (!spi_active) begin
        if (!mode_q && idx_q >= IW'(2)) begin
          rd_data_d = rx_data;
          rd_valid_d = 1'b1;
          rd_index_d = LEN_W'(idx_q - IW'(2));
        end
        if (idx_q == {1'b0, len_q} + IW'(1)) state_d = HOLD;
        else begin
          state_d = SEND;
          idx_d = idx_q + IW'(1);
        end
      end
      HOLD: begin
        state_d = GAP;
        done_d = 1'b1;
        gap_d = '0;
      end
      GAP: if (gap_q == GW'(CS_GAP - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // byte 0 is the command, byte 1 the address, the rest data (zero filler when reading)
    tx_byte_d = (state_d != SEND) ? tx_byte_q :
                (idx_d == '0) ? (mode_q ? 8'h0A : 8'h0B) :
                (idx_d == IW'(1)) ? addr_q :
                mode_q ? wr_data : 8'h00;
    start_d = state_d == SEND;
    wr_pop_d = (state_d == SEND) && mode_q && (idx_d >= IW'(2));
    ncs_d = !(state_d inside {SETUP, SEND, WAIT_ACK, WAIT_DONE, HOLD});
    clk_en_d = state_d inside {SETUP, SEND, WAIT_ACK, WAIT_DONE};
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      poll_q <= '0;
      tmr_q <= '0;
      gap_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      pend_q <= 1'b0;
      mode_q <= 1'b0;
      rd_data_q <= '0;
      rd_index_q <= '0;
      tx_byte_q <= '0;
      wr_pop_q <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      missed_q <= 1'b0;
      start_q <= 1'b0;
      ncs_q <= 1'b1;
      clk_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q <= poll_d;
      tmr_q <= tmr_d;
      gap_q <= gap_d;
      idx_q <= idx_d;
      len_q <= len_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      rd_data_q <= rd_data_d;
      rd_index_q <= rd_index_d;
      tx_byte_q <= tx_byte_d;
      wr_pop_q <= wr_pop_d;
      rd_valid_q <= rd_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      missed_q <= missed_d;
      start_q <= start_d;
      ncs_q <= ncs_d;
      clk_en_q <= clk_en_d;
    end
  end
  assign wr_pop = wr_pop_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_index = rd_index_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign missed_tick = missed_q;
  assign tx_byte = tx_byte_q;
  assign start = start_q;
  assign ncs_o = ncs_q;
  assign clk_enable = clk_en_q;
endmodule

// File: tb/tb_spi_burst_controller.sv
// tb_spi_burst_controller: randomized self-checking bench with byte engine model and transaction reference model
module tb_spi_burst_controller;
  localparam int PP = 20, ML = 8, LW = 4, AT = 16, CG = 2;
  logic clk = 0, rst_n = 0, poll_en = 0, req = 0, mode_write = 0;
  logic [7:0] cfg_addr = 0, wr_data = 0, rx_data = 0;
  logic [LW-1:0] cfg_len = 0;
  logic spi_active = 0;
  logic wr_pop, rd_valid, busy, done, err, missed_tick, start, ncs_o, clk_enable;
  logic [7:0] rd_data, tx_byte;
  logic [LW-1:0] rd_index;
  spi_burst_controller #(.POLL_PERIOD(PP), .MAX_LEN(ML), .LEN_W(LW), .ACK_TIMEOUT(AT), .CS_GAP(CG)) dut (
    .clk(clk), .rst_n(rst_n), .poll_en(poll_en), .req(req), .mode_write(mode_write),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index), .busy(busy), .done(done),
    .err(err), .missed_tick(missed_tick), .tx_byte(tx_byte), .start(start),
    .spi_active(spi_active), .rx_data(rx_data), .ncs_o(ncs_o), .clk_enable(clk_enable));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit eng_on = 1;
  int lat_max = 2, dur_max = 3;
  logic [7:0] rx_base = 0;
  int e_ph = 0, e_cnt = 0, e_n = 0, e_cur = 0;
  int cyc = 0, dones = 0, errs = 0, misses = 0, pops = 0, falls = 0;
  int err_cyc = 0, start_cyc = 0, hi_run = 0, min_gap = 1000;
  bit prev_ncs = 1, err_ncs = 0;
  logic [7:0] tx_log[$], rd_log[$], wq[$], wsrc[$], exp_tx[$], exp_rd[$];
  int ri_log[$], fall_cyc[$];
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // byte engine: raises spi_active a few cycles after start, returns rx_base + byte position
  initial forever begin
    @(negedge clk);
    if (ncs_o) e_n = 0;
    if (!rst_n || !eng_on) begin
      spi_active = 0;
      e_ph = 0;
    end else if (e_ph == 0) begin
      if (start) begin
        e_cur = e_n;
        e_n++;
        e_cnt = int'($urandom_range(lat_max, 0));
        e_ph = 1;
      end
    end else if (e_ph == 1) begin
      if (e_cnt == 0) begin
        spi_active = 1;
        e_cnt = int'($urandom_range(dur_max, 0));
        e_ph = 2;
      end else e_cnt--;
    end else begin
      if (e_cnt == 0) begin
        rx_data = rx_base + 8'(e_cur);
        spi_active = 0;
        e_ph = 0;
      end else e_cnt--;
    end
  end
  // monitor: logs bytes and pulses; also acts as write-data source that advances on wr_pop
  initial forever begin
    @(negedge clk);
    if (start) begin
      tx_log.push_back(tx_byte);
      start_cyc = cyc;
    end
    if (rd_valid) begin
      rd_log.push_back(rd_data);
      ri_log.push_back(int'(rd_index));
    end
    if (wr_pop) begin
      pops++;
      if (wq.size() > 0) void'(wq.pop_front());
      wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
    end
    if (done) dones++;
    if (err) begin
      errs++;
      err_cyc = cyc;
      err_ncs = ncs_o;
    end
    if (missed_tick) misses++;
    if (prev_ncs && !ncs_o) begin
      falls++;
      fall_cyc.push_back(cyc);
      if (hi_run < min_gap) min_gap = hi_run;
    end
    hi_run = ncs_o ? hi_run + 1 : 0;
    prev_ncs = ncs_o;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end
  function automatic int q_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction
  // reference: command, address, then min(len, ML) data bytes; reads return rx_base + position
  task automatic build_exp(input bit m, input logic [7:0] a, input int len);
    int n;
    n = (len > ML) ? ML : len;
    exp_tx.delete();
    exp_rd.delete();
    exp_tx.push_back(m ? 8'h0A : 8'h0B);
    exp_tx.push_back(a);
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(m ? wsrc[k] : 8'h00);
      if (!m) exp_rd.push_back(rx_base + 8'(k + 2));
    end
  endtask
  task automatic clr();
    tx_log.delete();
    rd_log.delete();
    ri_log.delete();
    fall_cyc.delete();
    dones = 0; errs = 0; misses = 0; pops = 0; falls = 0; min_gap = 1000;
  endtask
  task automatic pulse_req();
    @(negedge clk);
    req = 1;
    @(negedge clk);
    req = 0;
  endtask
  task automatic wait_end(input int n, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (dones + errs >= n) begin
        ok = 1;
        break;
      end
    end
    repeat (CG + 4) @(negedge clk);
  endtask
  task automatic run_txn(input bit m, input logic [7:0] a, input int len, output bit ok);
    clr();
    wq = wsrc;
    wr_data = (wsrc.size() > 0) ? wsrc[0] : 8'h00;
    mode_write = m;
    cfg_addr = a;
    cfg_len = LW'(len);
    build_exp(m, a, len);
    pulse_req();
    wait_end(1, 2000, ok);
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      tests++;
      if ({ncs_o, clk_enable, start, busy, done, err, missed_tick, rd_valid, wr_pop} !== 9'b1_0000_0000) begin
        fails++;
        $display("FAIL reset_ctrl phase %0d: got %b, required 100000000", p,
                 {ncs_o, clk_enable, start, busy, done, err, missed_tick, rd_valid, wr_pop});
      end
      tests++;
      if ({tx_byte, rd_data, rd_index} !== '0) begin
        fails++;
        $display("FAIL reset_data phase %0d: tx=%h rd=%h idx=%h, required zeros", p, tx_byte, rd_data, rd_index);
      end
      rst_n = 1;
      @(negedge clk);
    end
  endtask
  task automatic test_burst_read();
    bit ok;
    int d, bi;
    rx_base = 8'h0F;
    wsrc.delete();
    run_txn(0, 8'h0E, 6, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL burst_read_end: no done within bound, required done"); end
    d = q_diff(tx_log, exp_tx);
    tests++;
    if (d != -1) begin fails++; $display("FAIL burst_read_tx: diff at %0d, got %0d bytes, required %0d", d, tx_log.size(), exp_tx.size()); end
    d = q_diff(rd_log, exp_rd);
    tests++;
    if (d != -1) begin fails++; $display("FAIL burst_read_rd: diff at %0d, got %0d bytes, required %0d", d, rd_log.size(), exp_rd.size()); end
    bi = -1;
    foreach (ri_log[k]) if (ri_log[k] != k && bi < 0) bi = k;
    tests++;
    if (bi != -1) begin fails++; $display("FAIL burst_read_index: entry %0d got %0d, required %0d", bi, ri_log[bi], bi); end
    tests++;
    if (dones != 1 || falls != 1 || errs != 0 || pops != 0) begin
      fails++;
      $display("FAIL burst_read_pulses: done=%0d ncs_falls=%0d err=%0d pops=%0d, required 1 1 0 0", dones, falls, errs, pops);
    end
  endtask
  task automatic test_write();
    bit ok;
    int d;
    wsrc.delete();
    wsrc.push_back(8'h02);
    run_txn(1, 8'h2D, 1, ok);
    d = q_diff(tx_log, exp_tx);
    tests++;
    if (!ok || d != -1) begin fails++; $display("FAIL write_tx: ok=%0d diff=%0d got %0d bytes, required %0d", ok, d, tx_log.size(), exp_tx.size()); end
    tests++;
    if (pops != 1 || rd_log.size() != 0 || dones != 1) begin
      fails++;
      $display("FAIL write_pulses: pops=%0d rd_valid=%0d done=%0d, required 1 0 1", pops, rd_log.size(), dones);
    end
  endtask
  task automatic test_random();
    bit ok, m;
    int d, len, n;
    lat_max = 3;
    dur_max = 3;
    for (int i = 0; i < 10; i++) begin
      m = bit'($urandom_range(1, 0));
      len = int'($urandom_range(11, 0));
      n = (len > ML) ? ML : len;
      rx_base = 8'($urandom);
      wsrc.delete();
      for (int k = 0; k < 11; k++) wsrc.push_back(8'($urandom));
      run_txn(m, 8'($urandom), len, ok);
      d = q_diff(tx_log, exp_tx);
      tests++;
      if (!ok || d != -1) begin fails++; $display("FAIL random_tx %0d: m=%0d len=%0d diff=%0d got %0d bytes, required %0d", i, m, len, d, tx_log.size(), exp_tx.size()); end
      d = q_diff(rd_log, exp_rd);
      tests++;
      if (d != -1) begin fails++; $display("FAIL random_rd %0d: diff=%0d got %0d bytes, required %0d", i, d, rd_log.size(), exp_rd.size()); end
      tests++;
      if (pops != (m ? n : 0) || dones != 1 || falls != 1) begin
        fails++;
        $display("FAIL random_pulses %0d: pops=%0d done=%0d falls=%0d, required %0d 1 1", i, pops, dones, falls, m ? n : 0);
      end
    end
  endtask
  task automatic test_timeout();
    bit ok;
    clr();
    eng_on = 0;
    mode_write = 0;
    cfg_addr = 8'h44;
    cfg_len = 2;
    pulse_req();
    wait_end(1, 300, ok);
    tests++;
    if (!ok || errs != 1 || err_cyc - start_cyc != AT) begin
      fails++;
      $display("FAIL timeout_err: seen=%0d errs=%0d delay=%0d, required 1 1 %0d", ok, errs, err_cyc - start_cyc, AT);
    end
    tests++;
    if (err_ncs !== 1'b1 || dones != 0 || tx_log.size() != 1) begin
      fails++;
      $display("FAIL timeout_state: ncs=%b done=%0d bytes=%0d, required 1 0 1", err_ncs, dones, tx_log.size());
    end
    eng_on = 1;
    wsrc.delete();
    run_txn(0, 8'h45, 1, ok);
    tests++;
    if (!ok || dones != 1 || errs != 0 || q_diff(tx_log, exp_tx) != -1) begin
      fails++;
      $display("FAIL timeout_recover: done=%0d err=%0d bytes=%0d, required 1 0 %0d", dones, errs, tx_log.size(), exp_tx.size());
    end
  endtask
  task automatic test_pending();
    bit ok;
    clr();
    mode_write = 0;
    cfg_addr = 8'h10;
    cfg_len = 2;
    wsrc.delete();
    build_exp(0, 8'h10, 2);
    pulse_req();
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    pulse_req();
    repeat (2) @(negedge clk);
    pulse_req();
    wait_end(2, 2000, ok);
    repeat (40) @(negedge clk);
    tests++;
    if (!ok || dones != 2 || falls != 2) begin
      fails++;
      $display("FAIL pending_count: done=%0d falls=%0d, required 2 2", dones, falls);
    end
    tests++;
    if (min_gap < CG || tx_log.size() != 2 * exp_tx.size()) begin
      fails++;
      $display("FAIL pending_gap: ncs high %0d cycles, %0d bytes, required >=%0d and %0d", min_gap, tx_log.size(), CG, 2 * exp_tx.size());
    end
  endtask
  task automatic test_poll();
    int c0;
    lat_max = 0;
    dur_max = 0;
    clr();
    mode_write = 0;
    cfg_len = 2;
    @(negedge clk);
    c0 = cyc;
    poll_en = 1;
    repeat (3 * PP) @(negedge clk);
    poll_en = 0;
    repeat (40) @(negedge clk);
    tests++;
    if (falls != 3 || misses != 0 || dones != 3) begin
      fails++;
      $display("FAIL poll_count: falls=%0d missed=%0d done=%0d, required 3 0 3", falls, misses, dones);
    end
    tests++;
    if (falls < 2 || fall_cyc[0] - c0 != PP || fall_cyc[1] - fall_cyc[0] != PP) begin
      fails++;
      $display("FAIL poll_period: first=%0d interval=%0d, required %0d %0d", falls > 0 ? fall_cyc[0] - c0 : -1,
               falls > 1 ? fall_cyc[1] - fall_cyc[0] : -1, PP, PP);
    end
    clr();
    cfg_len = LW'(ML);
    @(negedge clk);
    poll_en = 1;
    repeat (4 * PP) @(negedge clk);
    poll_en = 0;
    repeat (60) @(negedge clk);
    tests++;
    if (falls + misses != 4 || misses < 1) begin
      fails++;
      $display("FAIL poll_missed: falls=%0d missed=%0d, required sum 4 with missed>=1", falls, misses);
    end
    lat_max = 2;
    dur_max = 3;
  endtask
  task automatic test_simultaneous();
    bit ok;
    int c0;
    clr();
    cfg_len = 1;
    @(negedge clk);
    c0 = cyc;
    poll_en = 1;
    repeat (PP - 1) @(negedge clk);
    req = 1;
    @(negedge clk);
    req = 0;
    poll_en = 0;
    wait_end(1, 500, ok);
    repeat (40) @(negedge clk);
    tests++;
    if (!ok || falls != 1 || dones != 1 || fall_cyc[0] - c0 != PP) begin
      fails++;
      $display("FAIL simultaneous: falls=%0d done=%0d start_delay=%0d, required 1 1 %0d", falls, dones,
               falls > 0 ? fall_cyc[0] - c0 : -1, PP);
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    clr();
    rx_base = 8'h20;
    mode_write = 0;
    cfg_addr = 8'h0E;
    cfg_len = 6;
    pulse_req();
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = tx_log.size() >= 3;
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (!ok || ncs_o !== 1'b1 || busy !== 1'b0 || clk_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_state: reached=%0d ncs=%b busy=%b clk_en=%b, required 1 1 0 0", ok, ncs_o, busy, clk_enable);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    tests++;
    if (dones != 0 || errs != 0) begin
      fails++;
      $display("FAIL reset_mid_pulses: done=%0d err=%0d, required 0 0", dones, errs);
    end
    wsrc.delete();
    run_txn(0, 8'h33, 0, ok);
    tests++;
    if (!ok || dones != 1 || q_diff(tx_log, exp_tx) != -1 || rd_log.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_len0: done=%0d bytes=%0d rd=%0d, required 1 2 0", dones, tx_log.size(), rd_log.size());
    end
  endtask
  initial begin
    test_reset();
    test_burst_read();
    test_write();
    test_random();
    test_timeout();
    test_pending();
    test_poll();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_burst_controller.md
SPI_BURST_CONTROLLER -- requirements
Module: spi_burst_controller

Interface
REQ-001 Parameter POLL_PERIOD, default 10000, clk cycles between automatic poll ticks.
REQ-002 Parameter MAX_LEN, default 8, maximum data bytes per transaction; LEN_W, default 4, width of length/index ports.
REQ-003 Parameter ACK_TIMEOUT, default 64, cycles allowed for spi_active to rise after start.
REQ-004 Parameter CS_GAP, default 2, minimum cycles ncs_o stays high between transactions.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 poll_en  in  1  enables automatic periodic transactions.
REQ-008 req  in  1  one-cycle request for a single transaction.
REQ-009 mode_write  in  1  0 = register read (command 0x0B), 1 = register write (command 0x0A).
REQ-010 cfg_addr  in  8  first register address.
REQ-011 cfg_len  in  LEN_W  data byte count.
REQ-012 wr_data  in  8  write byte, consumed on wr_pop.
REQ-013 wr_pop  out  1  one-cycle pulse: wr_data taken for the current byte.
REQ-014 rd_data / rd_valid / rd_index  out  8/1/LEN_W  received byte, one-cycle strobe, byte position from 0.
REQ-015 busy / done / err / missed_tick  out  1 each  transaction active; completion pulse; timeout-abort pulse; poll tick dropped pulse.
REQ-016 tx_byte / start  out  8/1  byte to the SPI byte engine; one-cycle launch strobe.
REQ-017 spi_active / rx_data  in  1/8  engine busy flag; byte received by the engine.
REQ-018 ncs_o / clk_enable  out  1/1  chip select (active low); SPI clock enable.

Function
REQ-019 The poll counter SHALL count 0..POLL_PERIOD-1 while poll_en=1, produce a tick at terminal count, wrap to 0, and hold at 0 while poll_en=0.
REQ-020 A transaction SHALL start from IDLE on req or a poll tick; if both occur in the same cycle, exactly one transaction SHALL run.
REQ-021 A req arriving while busy=1 SHALL be latched as pending and serviced after the CS_GAP; further reqs while one is pending SHALL be merged.
REQ-022 A poll tick arriving while busy=1 SHALL be dropped and SHALL pulse missed_tick for one cycle.
REQ-023 mode_write, cfg_addr and cfg_len SHALL be latched at transaction start; cfg_len > MAX_LEN SHALL clamp to MAX_LEN.
REQ-024 States SHALL be: IDLE -> SETUP (1 cycle, ncs_o=0, clk_enable=1) -> SEND -> WAIT_ACK -> WAIT_DONE -> (SEND for the next byte | HOLD) -> GAP -> IDLE.
REQ-025 The byte sequence SHALL be: command, address, then the latched length of data bytes; read data bytes SHALL send tx_byte=0x00.
REQ-026 SEND SHALL drive start=1 for exactly one cycle with tx_byte valid; in write mode, wr_pop SHALL pulse in the SEND cycle of each data byte.
REQ-027 WAIT_ACK SHALL wait for spi_active=1; WAIT_DONE SHALL wait for spi_active=0.
REQ-028 In read mode, on leaving WAIT_DONE for a data byte, rx_data SHALL be registered into rd_data, with rd_valid=1 for one cycle and rd_index set to that byte's position.
REQ-029 cfg_len=0 SHALL send command and address only and SHALL still pulse done.
REQ-030 If spi_active does not rise within ACK_TIMEOUT cycles of start, the controller SHALL abort: ncs_o=1, clk_enable=0, err pulse, enter GAP, no done.
REQ-031 HOLD SHALL last 1 cycle with ncs_o=0 and clk_enable=0; done SHALL pulse on HOLD exit.
REQ-032 GAP SHALL keep ncs_o=1 for CS_GAP cycles.
REQ-033 busy SHALL be 1 from SETUP through the end of GAP.
REQ-034 clk_enable SHALL be registered and SHALL be 1 only from SETUP through the last WAIT_DONE.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, ncs_o=1, clk_enable=0, start=0, tx_byte=0, rd_data=0, rd_index=0, all strobes=0, busy=0, poll counter=0, and pending cleared.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no done or err pulse.
REQ-037 After rst_n release, the first poll tick SHALL occur POLL_PERIOD cycles later if poll_en=1.

Verification
REQ-038 Burst read: req, mode_write=0, cfg_addr=0x0E, cfg_len=6, engine model returns 0x11..0x16 -> tx_byte sequence 0x0B,0x0E,0x00x6; rd_valid x6 with rd_index 0..5 and rd_data 0x11..0x16; one done; ncs_o low throughout.
REQ-039 Write: mode_write=1, cfg_addr=0x2D, cfg_len=1, wr_data=0x02 -> bytes 0x0A,0x2D,0x02; one wr_pop; no rd_valid; done.
REQ-040 Polling: POLL_PERIOD=20, poll_en=1, cfg_len=2 -> a transaction every 20 cycles; a tick landing during busy pulses missed_tick.
REQ-041 Timeout: engine never raises spi_active -> err pulse ACK_TIMEOUT cycles after start; ncs_o=1; no done; next req succeeds.
REQ-042 Simultaneous and pending requests: req coincident with a tick yields one transaction; req during busy yields exactly one follow-up after CS_GAP cycles of ncs_o=1.
REQ-043 Reset mid-burst: rst_n=0 during byte 3 -> ncs_o=1 and busy=0 in the same cycle; no done; cfg_len=0 request afterwards yields 2 bytes and done.
